// File: rtl/axi_addr_route_arb.sv
// axi_addr_route_arb: AXI address-channel router with range decode, base strip, per-target round-robin and registered slots.
// Define AXI_DECERR_EN to send unmapped requests to a decode-error slot instead of DEFAULT_S.
module axi_addr_route_arb #(
  parameter int NO_M = 4,
  parameter int NO_S = 6,
  parameter int ADDR_W = 32,
  parameter int M_ID_W = 9,
  parameter int S_ID_W = 11,
  parameter int LEN_W = 8,
  parameter logic [NO_S*ADDR_W-1:0] S_START = {32'h202000, 32'h200000, 32'h100000, 32'h4000, 32'h2000, 32'h0},
  parameter logic [NO_S*ADDR_W-1:0] S_END = {32'h203fff, 32'h201fff, 32'h1fffff, 32'h7fff, 32'h3fff, 32'hfff},
  parameter int DEFAULT_S = 0
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [NO_M-1:0]          m_avalid,
  output logic [NO_M-1:0]          m_aready,
  input  logic [NO_M*ADDR_W-1:0]   m_aaddr,
  input  logic [NO_M*M_ID_W-1:0]   m_aid,
  input  logic [NO_M*LEN_W-1:0]    m_alen,
  output logic [NO_S-1:0]          s_avalid,
  input  logic [NO_S-1:0]          s_aready,
  output logic [NO_S*ADDR_W-1:0]   s_aaddr,
  output logic [NO_S*S_ID_W-1:0]   s_aid,
  output logic [NO_S*LEN_W-1:0]    s_alen,
  output logic                     decerr_valid,
  input  logic                     decerr_ready,
  output logic [S_ID_W-1:0]        decerr_id
);
  localparam int MW = $clog2(NO_M);
  localparam int NT = NO_S + 1;
  localparam int TW = $clog2(NT);
`ifdef AXI_DECERR_EN
  localparam int MISS_T = NO_S;
`else
  localparam int MISS_T = DEFAULT_S;
`endif
  if (S_ID_W < M_ID_W + MW) begin : g_id_chk
    $error("S_ID_W too narrow to hold master index and master ID");
  end
  function automatic logic [MW-1:0] rot(input logic [MW-1:0] b, input int k);
    return MW'((int'(b) + k) % NO_M);
  endfunction
  logic [TW-1:0]     w_tgt [NO_M];
  logic [ADDR_W-1:0] w_off [NO_M];
  logic [S_ID_W-1:0] w_xid [NO_M];
  logic [LEN_W-1:0]  w_len [NO_M];
  logic [NT-1:0]     w_rdy, w_load, w_any;
  logic [MW-1:0]     w_win [NT];
  logic [NT-1:0]     r_valid;
  logic [ADDR_W-1:0] r_addr [NT];
  logic [S_ID_W-1:0] r_id [NT];
  logic [LEN_W-1:0]  r_len [NT];
  logic [MW-1:0]     r_rr [NT];
  assign w_rdy = {decerr_ready, s_aready};
  assign w_load = ~r_valid | w_rdy;
  // Descending scan so the lowest-indexed matching slave is the last writer.
  always_comb begin
    for (int i = 0; i < NO_M; i++) begin
      w_tgt[i] = TW'(MISS_T);
      w_off[i] = m_aaddr[i*ADDR_W +: ADDR_W];
      w_xid[i] = S_ID_W'({MW'(i), m_aid[i*M_ID_W +: M_ID_W]});
      w_len[i] = m_alen[i*LEN_W +: LEN_W];
      for (int s = NO_S - 1; s >= 0; s--)
        if (m_aaddr[i*ADDR_W +: ADDR_W] >= S_START[s*ADDR_W +: ADDR_W] &&
            m_aaddr[i*ADDR_W +: ADDR_W] <= S_END[s*ADDR_W +: ADDR_W]) begin
          w_tgt[i] = TW'(s);
          w_off[i] = m_aaddr[i*ADDR_W +: ADDR_W] - S_START[s*ADDR_W +: ADDR_W];
        end
    end
  end
  always_comb begin
    m_aready = '0;
    for (int t = 0; t < NT; t++) begin
      w_any[t] = 1'b0;
      w_win[t] = '0;
      for (int k = NO_M - 1; k >= 0; k--)
        if (m_avalid[rot(r_rr[t], k)] && w_tgt[rot(r_rr[t], k)] == TW'(t)) begin
          w_any[t] = 1'b1;
          w_win[t] = rot(r_rr[t], k);
        end
      if (w_any[t] && w_load[t] && !ARESET) m_aready[w_win[t]] = 1'b1;
    end
  end
  always_ff @(posedge ACLK)
    if (ARESET) begin
      r_valid <= '0;
      r_addr <= '{default: '0};
      r_id <= '{default: '0};
      r_len <= '{default: '0};
      r_rr <= '{default: '0};
    end else
      for (int t = 0; t < NT; t++)
        if (w_load[t]) begin
          r_valid[t] <= w_any[t];
          if (w_any[t]) begin
            r_addr[t] <= w_off[w_win[t]];
            r_id[t] <= w_xid[w_win[t]];
            r_len[t] <= w_len[w_win[t]];
            r_rr[t] <= (w_win[t] == MW'(NO_M - 1)) ? '0 : w_win[t] + 1'b1;
          end
        end
  for (genvar s = 0; s < NO_S; s++) begin : g_out
    assign s_aaddr[s*ADDR_W +: ADDR_W] = r_addr[s];
    assign s_aid[s*S_ID_W +: S_ID_W] = r_id[s];
    assign s_alen[s*LEN_W +: LEN_W] = r_len[s];
  end
  assign s_avalid = r_valid[NO_S-1:0];
`ifdef AXI_DECERR_EN
  assign decerr_valid = r_valid[NO_S];
  assign decerr_id = r_id[NO_S];
`else
  assign decerr_valid = 1'b0;
  assign decerr_id = '0;
`endif
endmodule

// File: tb/tb_axi_addr_route_arb.sv
// tb_axi_addr_route_arb: directed stimulus with a per-cycle reference model of the router plus literal spot checks.
module tb_axi_addr_route_arb;
  localparam int NM = 4;
  localparam int NS = 6;
  logic clk = 0;
  logic rst = 1;
  logic [NM-1:0] m_avalid, m_aready;
  logic [NM*32-1:0] m_aaddr;
  logic [NM*9-1:0] m_aid;
  logic [NM*8-1:0] m_alen;
  logic [NS-1:0] s_avalid, s_aready;
  logic [NS*32-1:0] s_aaddr;
  logic [NS*11-1:0] s_aid;
  logic [NS*8-1:0] s_alen;
  logic decerr_valid, decerr_ready;
  logic [10:0] decerr_id;
  int total = 0;
  int bad = 0;
  bit run = 0;
  int unsigned st[NS] = '{32'h0, 32'h2000, 32'h4000, 32'h100000, 32'h200000, 32'h202000};
  int unsigned en[NS] = '{32'hfff, 32'h3fff, 32'h7fff, 32'h1fffff, 32'h201fff, 32'h203fff};
  bit mv[NS+1];
  int unsigned ma[NS+1];
  int mi[NS+1];
  int ml[NS+1];
  int rr[NS+1];
  always #5 clk = ~clk;
  axi_addr_route_arb dut (
    .ACLK(clk), .ARESET(rst),
    .m_avalid(m_avalid), .m_aready(m_aready), .m_aaddr(m_aaddr), .m_aid(m_aid), .m_alen(m_alen),
    .s_avalid(s_avalid), .s_aready(s_aready), .s_aaddr(s_aaddr), .s_aid(s_aid), .s_alen(s_alen),
    .decerr_valid(decerr_valid), .decerr_ready(decerr_ready), .decerr_id(decerr_id)
  );
  task automatic check(input string n, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  function automatic int tgt_of(input int unsigned a);
    for (int s = 0; s < NS; s++) if (a >= st[s] && a <= en[s]) return s;
`ifdef AXI_DECERR_EN
    return NS;
`else
    return 0;
`endif
  endfunction
  function automatic int unsigned off_of(input int unsigned a);
    int t = tgt_of(a);
    return (t < NS && a >= st[t] && a <= en[t]) ? a - st[t] : a;
  endfunction
  // Reference model: check outputs against modelled slots, then advance the model to the next edge.
  always @(negedge clk) if (run) begin : cmp
    logic [NM-1:0] er;
    bit can[NS+1];
    int win[NS+1];
    int w;
    er = '0;
    for (int s = 0; s <= NS; s++) begin
      can[s] = !mv[s] || (s < NS ? s_aready[s] : decerr_ready);
      win[s] = -1;
      for (int k = 0; k < NM; k++) begin
        w = (rr[s] + k) % NM;
        if (win[s] < 0 && m_avalid[w] && tgt_of(m_aaddr[w*32 +: 32]) == s) win[s] = w;
      end
      if (can[s] && win[s] >= 0 && !rst) er[win[s]] = 1'b1;
    end
    check("model_aready", m_aready, er);
    for (int s = 0; s < NS; s++) begin
      check($sformatf("model_svalid%0d", s), s_avalid[s], mv[s]);
      if (mv[s]) begin
        check($sformatf("model_saddr%0d", s), s_aaddr[s*32 +: 32], ma[s]);
        check($sformatf("model_sid%0d", s), s_aid[s*11 +: 11], mi[s]);
        check($sformatf("model_slen%0d", s), s_alen[s*8 +: 8], ml[s]);
      end
    end
`ifdef AXI_DECERR_EN
    check("model_decerr_valid", decerr_valid, mv[NS]);
    if (mv[NS]) check("model_decerr_id", decerr_id, mi[NS]);
`else
    check("model_decerr_valid", decerr_valid, 0);
    check("model_decerr_id", decerr_id, 0);
`endif
    for (int s = 0; s <= NS; s++)
      if (rst) begin
        mv[s] = 0; ma[s] = 0; mi[s] = 0; ml[s] = 0; rr[s] = 0;
      end else if (can[s]) begin
        mv[s] = win[s] >= 0;
        if (mv[s]) begin
          ma[s] = off_of(m_aaddr[win[s]*32 +: 32]);
          mi[s] = (win[s] << 9) | int'(m_aid[win[s]*9 +: 9]);
          ml[s] = int'(m_alen[win[s]*8 +: 8]);
          rr[s] = (win[s] + 1) % NM;
        end
      end
  end
  task automatic put(input int m, input int unsigned a, input int id, input int len);
    m_avalid[m] = 1'b1;
    m_aaddr[m*32 +: 32] = a;
    m_aid[m*9 +: 9] = 9'(id);
    m_alen[m*8 +: 8] = 8'(len);
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  initial begin
    m_avalid = '1;
    m_aaddr = {NM{32'h4000}};
    m_aid = '0;
    m_alen = '0;
    s_aready = '1;
    decerr_ready = 1'b1;
    @(posedge clk);
    run = 1;
    repeat (3) begin
      smp;
      check("rst_aready", m_aready, 0);
      check("rst_svalid", s_avalid, 0);
      check("rst_decerr", decerr_valid, 0);
    end
    nxt;
    rst = 0;
    m_avalid = '0;
    put(1, 32'h2010, 5, 3);
    smp;
    check("dec_grant", m_aready, 4'b0010);
    nxt;
    m_avalid = '0;
    smp;
    check("dec_valid", s_avalid[1], 1);
    check("dec_addr", s_aaddr[63:32], 32'h10);
    check("dec_id", s_aid[21:11], 11'h205);
    nxt;
    for (int m = 0; m < NM; m++) put(m, 32'h4000, m + 8, m);
    for (int k = 0; k < 5; k++) begin
      smp;
      check($sformatf("rr_%0d", k), m_aready, 1 << (k % 4));
      nxt;
    end
    m_avalid = '0;
    s_aready[3] = 1'b0;
    put(1, 32'h100020, 7, 1);
    smp;
    check("bp_fill", m_aready, 4'b0010);
    nxt;
    m_avalid = '0;
    put(0, 32'h100000, 1, 2);
    put(2, 32'h200004, 3, 4);
    for (int k = 0; k < 3; k++) begin
      smp;
      check("bp_grant", m_aready, 4'b0100);
      check("bp_s3valid", s_avalid[3], 1);
      check("bp_s3addr", s_aaddr[127:96], 32'h20);
      if (k > 0) check("bp_s4addr", s_aaddr[159:128], 32'h4);
      nxt;
    end
    s_aready[3] = 1'b1;
    smp;
    check("bp_release", m_aready, 4'b0101);
    nxt;
    m_avalid = '0;
    put(3, 32'hfff, 'h1a, 0);
    nxt;
    put(3, 32'h1000, 'h1b, 0);
    smp;
    check("bnd_fff_addr", s_aaddr[31:0], 32'hfff);
    check("bnd_fff_id", s_aid[10:0], 11'h61a);
    nxt;
    m_avalid = '0;
    smp;
`ifdef AXI_DECERR_EN
    check("bnd_1000_decerr", decerr_valid, 1);
    check("bnd_1000_id", decerr_id, 11'h61b);
`else
    check("bnd_1000_valid", s_avalid[0], 1);
    check("bnd_1000_addr", s_aaddr[31:0], 32'h1000);
    check("bnd_1000_id", s_aid[10:0], 11'h61b);
`endif
    nxt;
    put(0, 32'h3fff, 2, 1);
    put(1, 32'h1fffff, 3, 2);
    put(2, 32'h203fff, 4, 3);
    put(3, 32'h204000, 5, 4);
    nxt;
    m_avalid = '0;
    nxt;
    s_aready[2] = 1'b0;
    put(1, 32'h4000, 9, 0);
    smp;
    check("mid_fill", m_aready, 4'b0010);
    nxt;
    for (int m = 0; m < NM; m++) put(m, 32'h4000, m, 0);
    smp;
    check("mid_block", m_aready, 0);
    nxt;
    rst = 1;
    smp;
    check("mid_rst_aready", m_aready, 0);
    nxt;
    rst = 0;
    s_aready[2] = 1'b1;
    smp;
    check("mid_cleared", s_avalid[2], 0);
    check("mid_first", m_aready, 4'b0001);
    nxt;
    m_avalid = '0;
    repeat (3) nxt;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
